action_conditioner: RTL and testbench
=====================================

# action_conditioner

Conditions the four raw player buttons into the frame-aligned `actions` vector consumed by the game top level and tetrimino logic. It sits directly upstream of that top level and performs synchronisation, per-button debounce, and press-edge detection. It also applies delayed auto-shift/auto-repeat to selected buttons. Every event is presented for exactly one display frame, delimited by rising edges of the `vsync` produced by the VGA controller.

## Interface
- `N_BUTTONS`, 4, number of buttons. Bit 0 right, 1 left, 2 rotate, 3 drop.
- `DEBOUNCE_CYCLES`, 250000, consecutive cycles a synced level must differ from the stable level before it is accepted; must be ≥1.
- `DAS_FRAMES`, 10, frames from accepted press to first auto-repeat; must be ≥1.
- `ARR_FRAMES`, 3, frames between subsequent auto-repeats; must be ≥1.
- `REPEAT_MASK`, 4'b0011, buttons allowed to auto-repeat; others fire once per press.
- `clock  input  1  system clock; same domain as vga_control`
- `reset_n  input  1  asynchronous, active-low reset`
- `buttons_raw  input  N_BUTTONS  asynchronous, bouncy, active-high buttons`
- `vsync  input  1  frame marker from VGA controller, synchronous to clock`
- `actions  output  N_BUTTONS  one-frame action pulses to game logic`
- `frame_tick  output  1  one-cycle pulse on each vsync rising edge`

## Operation
- Synchroniser: two flops per button, reset to 0.
- Debounce, per button:
  - Holds a `stable` level and a counter.
  - If `synced != stable`, the counter increments. When it reaches DEBOUNCE_CYCLES−1 with the mismatch still present, `stable <= synced` and the counter clears.
  - Any cycle with `synced == stable` clears the counter.
- Frame edge: `vsync_q` registered; `frame_tick = vsync & ~vsync_q`.
- Per-button FSM with states IDLE, DELAY, REPEAT and a frame counter sized for max(DAS_FRAMES, ARR_FRAMES):
  - IDLE: on `stable` rising, set `pending`, clear the counter, go to DELAY.
  - DELAY: if `stable` = 0, go to IDLE. Otherwise increment the counter on each `frame_tick`.
    - Counter reaches DAS_FRAMES, `REPEAT_MASK` bit = 1: set `pending`, clear the counter, go to REPEAT.
    - Counter reaches DAS_FRAMES, `REPEAT_MASK` bit = 0: stay in DELAY with the counter saturated.
  - REPEAT: if `stable` = 0, go to IDLE. Otherwise increment the counter on each `frame_tick`; on reaching ARR_FRAMES, set `pending` and clear the counter.
  - Release has priority over a same-cycle repeat expiry; the repeat is not generated.
- Output latch on each `frame_tick`:
  - `actions <= pending | set_now`, where `set_now` is any pending-set occurring in the same cycle.
  - `pending <= 0`.
  - So an event coinciding with `frame_tick` goes straight into `actions`: never lost, never duplicated.
- Multiple sets of the same bit within one frame collapse into one event.
- Buttons are independent; simultaneous presses of several buttons are all reported in the same frame.

## Timing
- All outputs reset to 0: `actions`, `frame_tick`, `pending`, sync flops, `stable`, counters, FSM = IDLE.
- Reset asserted mid-frame clears everything immediately. After release, a button already held is treated as a new press once debounced.
- Press latency: 2 (sync) + DEBOUNCE_CYCLES cycles to `stable`, plus 1 cycle to `pending`, plus a wait for the next `frame_tick`, plus 1 cycle to `actions`.
- `actions` changes only in the cycle after a `frame_tick` and is held constant for the whole frame.
- `frame_tick` lags the vsync rising edge by one cycle and is high for exactly one cycle.
- A held repeat button produces events in frames F0, F0+DAS_FRAMES, then every ARR_FRAMES frames after that.
- Glitches shorter than DEBOUNCE_CYCLES never reach `actions`.

## Structure
- Shared package `petris_input_pkg` holds:
  - button index constants `BTN_RIGHT=0`, `BTN_LEFT=1`, `BTN_ROTATE=2`, `BTN_DROP=3`;
  - the FSM state enum `das_state_t` {IDLE, DELAY, REPEAT}.
- Sub-module `input_debouncer` (synchroniser + debounce for one bit, parameterised by DEBOUNCE_CYCLES), instantiated N_BUTTONS times.
- FSMs and the output latch live in the parent.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, DAS_FRAMES=3, ARR_FRAMES=1; vsync period 20 cycles.
- Reset held then released, inputs 0 → `actions`=0 and `frame_tick` pulses once per vsync edge.
- `buttons_raw[0]` toggling every 2 cycles for 30 cycles, then 0 → `actions` stays 0 throughout.
- `buttons_raw[2]` held for 10 frames → `actions`=4'b0100 for exactly one frame, then 0 while still held.
- `buttons_raw[1]` held for 8 frames → bit 1 set in frames F0, F3, F4, F5, F6, F7 and clear in F1 and F2.
- Press bit 3 debounced in the same cycle as `frame_tick` → `actions`=4'b1000 on the next cycle; not repeated in the following frame.
- Reset asserted mid-REPEAT with bit 0 held → `actions` drops to 0 asynchronously. After release, bit 0 reappears one frame after re-debounce, with a new DAS delay.

Source files
------------

// File: rtl/petris_input_pkg.sv
// Shared definitions for the Petris button-input path: button indices and the
// per-button auto-shift state encoding.
package petris_input_pkg;

   localparam int unsigned BTN_RIGHT  = 0;
   localparam int unsigned BTN_LEFT   = 1;
   localparam int unsigned BTN_ROTATE = 2;
   localparam int unsigned BTN_DROP   = 3;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } das_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a counter debounce for a single button.
module input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic button_raw,
   output logic stable
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         count_q  <= '0;
      end else begin
         sync1_q <= button_raw;
         sync2_q <= sync1_q;
         if (sync2_q != stable_q) begin
            // Accept the new level on the DEBOUNCE_CYCLES-th consecutive mismatch.
            if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               stable_q <= sync2_q;
               count_q  <= '0;
            end else begin
               count_q <= count_q + CW'(1);
            end
         end else begin
            count_q <= '0;
         end
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/action_conditioner.sv
// Turns raw buttons into frame-aligned one-frame action pulses, with delayed
// auto-shift / auto-repeat on the buttons selected by REPEAT_MASK.
module action_conditioner
   import petris_input_pkg::*;
#(
   parameter int unsigned N_BUTTONS       = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned DAS_FRAMES      = 10,
   parameter int unsigned ARR_FRAMES      = 3,
   parameter logic [N_BUTTONS-1:0] REPEAT_MASK = N_BUTTONS'(4'b0011)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [N_BUTTONS-1:0] buttons_raw,
   input  logic                 vsync,
   output logic [N_BUTTONS-1:0] actions,
   output logic                 frame_tick
);

   localparam int unsigned MAX_FRAMES = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
   localparam int unsigned FW = $clog2(MAX_FRAMES + 1);

   logic [N_BUTTONS-1:0] stable;
   logic [N_BUTTONS-1:0] set_now;
   logic [N_BUTTONS-1:0] pending_q;
   logic [N_BUTTONS-1:0] actions_q;
   logic                 vsync_q;
   logic                 frame_tick_q;
   das_state_t           state_q [N_BUTTONS];
   logic [FW-1:0]        count_q [N_BUTTONS];

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
      input_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clock     (clock),
         .reset_n   (reset_n),
         .button_raw(buttons_raw[g]),
         .stable    (stable[g])
      );
   end

   // DELAY only counts once the initial press has been presented, so the
   // first repeat lands DAS_FRAMES frames after the press frame.
   always_comb begin
      set_now = '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
         case (state_q[i])
            IDLE:    set_now[i] = stable[i];
            DELAY:   set_now[i] = stable[i] && frame_tick_q && !pending_q[i] && REPEAT_MASK[i] &&
                                  (count_q[i] == FW'(DAS_FRAMES - 1));
            REPEAT:  set_now[i] = stable[i] && frame_tick_q &&
                                  (count_q[i] == FW'(ARR_FRAMES - 1));
            default: set_now[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vsync_q      <= 1'b0;
         frame_tick_q <= 1'b0;
         pending_q    <= '0;
         actions_q    <= '0;
         for (int i = 0; i < N_BUTTONS; i++) begin
            state_q[i] <= IDLE;
            count_q[i] <= '0;
         end
      end else begin
         vsync_q      <= vsync;
         frame_tick_q <= vsync & ~vsync_q;
         if (frame_tick_q) begin
            actions_q <= pending_q | set_now;
            pending_q <= '0;
         end else begin
            pending_q <= pending_q | set_now;
         end
         for (int i = 0; i < N_BUTTONS; i++) begin
            case (state_q[i])
               IDLE: begin
                  // IDLE is only entered with the button released, so a high level is a press.
                  if (stable[i]) begin
                     count_q[i] <= '0;
                     state_q[i] <= DELAY;
                  end
               end
               DELAY: begin
                  if (!stable[i]) begin
                     state_q[i] <= IDLE;
                  end else if (frame_tick_q && !pending_q[i] &&
                               count_q[i] != FW'(DAS_FRAMES)) begin
                     if (REPEAT_MASK[i] && count_q[i] == FW'(DAS_FRAMES - 1)) begin
                        count_q[i] <= '0;
                        state_q[i] <= REPEAT;
                     end else begin
                        count_q[i] <= count_q[i] + FW'(1);
                     end
                  end
               end
               REPEAT: begin
                  if (!stable[i]) begin
                     state_q[i] <= IDLE;
                  end else if (frame_tick_q) begin
                     if (count_q[i] == FW'(ARR_FRAMES - 1)) begin
                        count_q[i] <= '0;
                     end else begin
                        count_q[i] <= count_q[i] + FW'(1);
                     end
                  end
               end
               default: state_q[i] <= IDLE;
            endcase
         end
      end
   end

   assign actions    = actions_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_action_conditioner.sv
// Directed plus randomized bench for action_conditioner, checked every cycle
// against a frame-level behavioural model.
module tb_action_conditioner;
   import petris_input_pkg::*;

   localparam int unsigned NB   = 4;
   localparam int unsigned DEB  = 4;
   localparam int unsigned DAS  = 3;
   localparam int unsigned ARR  = 1;
   localparam int unsigned VPER = 20;
   localparam logic [3:0]  MASK = 4'b0011;

   logic          clock       = 1'b0;
   logic          reset_n     = 1'b0;
   logic [NB-1:0] buttons_raw = '0;
   logic          vsync       = 1'b0;
   logic [NB-1:0] actions;
   logic          frame_tick;

   action_conditioner #(
      .N_BUTTONS      (NB),
      .DEBOUNCE_CYCLES(DEB),
      .DAS_FRAMES     (DAS),
      .ARR_FRAMES     (ARR),
      .REPEAT_MASK    (MASK)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .buttons_raw(buttons_raw),
      .vsync      (vsync),
      .actions    (actions),
      .frame_tick (frame_tick)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int phase = 0;

   // Reference model state
   logic [NB-1:0]  r1, r2, stab, pend, active, f0, exp_act;
   logic [DEB-1:0] hist [NB];
   int             k [NB];
   logic           tick_m, vprev;

   task automatic model_reset();
      r1 = '0; r2 = '0; stab = '0; pend = '0; active = '0; f0 = '0; exp_act = '0;
      tick_m = 1'b0; vprev = 1'b0;
      for (int i = 0; i < NB; i++) begin
         hist[i] = '0;
         k[i]    = 0;
      end
   endtask

   task automatic model_edge();
      logic [NB-1:0] synced;
      logic          bnd;
      logic          ev;
      bnd    = tick_m;
      synced = r2;
      r2     = r1;
      r1     = buttons_raw;
      tick_m = vsync & ~vprev;
      vprev  = vsync;
      for (int i = 0; i < NB; i++) begin
         if (active[i] && !stab[i]) active[i] = 1'b0;
         if (!active[i] && stab[i]) begin
            active[i] = 1'b1;
            pend[i]   = 1'b1;
            f0[i]     = 1'b0;
         end
         if (bnd) begin
            ev = 1'b0;
            // k = frames elapsed since the press frame F0
            if (active[i] && f0[i]) begin
               k[i]++;
               if (MASK[i] && (k[i] == DAS || (k[i] > DAS && (k[i] - DAS) % ARR == 0))) ev = 1'b1;
            end
            if (pend[i]) begin
               ev = 1'b1;
               if (active[i]) begin
                  f0[i] = 1'b1;
                  k[i]  = 0;
               end
               pend[i] = 1'b0;
            end
            exp_act[i] = ev;
         end
         hist[i] = {hist[i][DEB-2:0], synced[i]};
         if (hist[i] == {DEB{~stab[i]}}) stab[i] = ~stab[i];
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic step();
      vsync = (phase < VPER / 2);
      phase = (phase + 1) % VPER;
      @(posedge clock);
      if (reset_n) model_edge();
      else model_reset();
      #1;
      check("actions", 32'(actions), 32'(exp_act));
      check("frame_tick", 32'(frame_tick), 32'(tick_m));
   endtask

   task automatic run(input int n);
      for (int j = 0; j < n; j++) step();
   endtask

   initial begin
      int          nt;
      logic [NB-1:0] seen;
      model_reset();

      // Reset, then idle: frame_tick once per vsync period
      run(3);
      check("reset_actions", 32'(actions), 32'd0);
      reset_n = 1'b1;
      run(VPER);
      nt = 0;
      for (int j = 0; j < 3 * VPER; j++) begin
         step();
         if (frame_tick) nt++;
      end
      check("tick_count", 32'(nt), 32'd3);

      // Bounce shorter than the debounce window never shows up
      seen = '0;
      for (int j = 0; j < 15; j++) begin
         buttons_raw[BTN_RIGHT] = ~buttons_raw[BTN_RIGHT];
         step(); seen |= actions;
         step(); seen |= actions;
      end
      buttons_raw = '0;
      for (int j = 0; j < 2 * VPER; j++) begin
         step();
         seen |= actions;
      end
      check("glitch_free", 32'(seen), 32'd0);

      // Rotate held 10 frames: exactly one frame of 4'b0100
      buttons_raw[BTN_ROTATE] = 1'b1;
      nt = 0;
      for (int j = 0; j < 10 * VPER; j++) begin
         step();
         if (actions == 4'b0100) nt++;
      end
      check("rotate_once", 32'(nt), 32'(VPER));
      buttons_raw = '0;
      run(2 * VPER);

      // Left held 8 frames: DAS then auto-repeat every frame
      buttons_raw[BTN_LEFT] = 1'b1;
      run(8 * VPER);
      buttons_raw = '0;
      run(2 * VPER);

      // Drop debounced in the same cycle frame_tick rises
      while (phase != 15) step();
      buttons_raw[BTN_DROP] = 1'b1;
      run(6);
      check("drop_before", 32'(actions), 32'd0);
      step();
      check("drop_aligned", 32'(actions), 32'b1000);
      run(VPER);
      check("drop_no_repeat", 32'(actions), 32'd0);
      buttons_raw = '0;
      run(2 * VPER);

      // Reset in the middle of auto-repeat, button still held
      buttons_raw[BTN_RIGHT] = 1'b1;
      run(6 * VPER + 7);
      check("repeat_active", 32'(actions), 32'b0001);
      reset_n = 1'b0;
      #1;
      check("reset_async", 32'(actions), 32'd0);
      run(3);
      reset_n = 1'b1;
      run(8 * VPER);
      buttons_raw = '0;
      run(2 * VPER);

      // Random button patterns
      for (int j = 0; j < 40; j++) begin
         buttons_raw = NB'($urandom_range(0, 15));
         run(int'($urandom_range(1, 70)));
      end
      buttons_raw = '0;
      run(3 * VPER);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
